reg_alu_sequencer: RTL

- Execute stage that sits directly downstream of the 4x32 register bank and also drives it.
- Accepts one register-to-register instruction at a time over a valid/ready handshake and drives the bank's read selects sr1/sr2.
- Captures the bank's rdData1/rdData2, computes the ALU result (including a multi-cycle shift-add multiply), then writes back through dr/wrData/write.
- Throughput is one instruction per 4 cycles, or 35 cycles for MUL.

---
 rtl/reg_alu_sequencer_pkg.sv | 26 ++
 rtl/reg_alu_sequencer_if.sv | 36 +++
 rtl/reg_alu_sequencer_mul.sv | 66 ++++++
 rtl/reg_alu_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/reg_alu_sequencer_pkg.sv
// Shared definitions for the register-bank execute stage: opcodes, FSM states
// and default widths.
package reg_alu_sequencer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/reg_alu_sequencer_if.sv
// Instruction handshake plus register-bank read/write bus seen by the execute
// stage. slave = execute stage view, master = upstream/bank view.
interface reg_alu_sequencer_if
  import reg_alu_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_sr1;
  logic [ADDR_W-1:0] instr_sr2;
  logic [ADDR_W-1:0] instr_dr;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;
  logic [ADDR_W-1:0] dr;
  logic [DATA_W-1:0] wrData;
  logic              write;

  modport slave (
    input  instr_valid, instr_op, instr_sr1, instr_sr2, instr_dr,
    input  rdData1, rdData2,
    output instr_ready, sr1, sr2, dr, wrData, write
  );

  modport master (
    output instr_valid, instr_op, instr_sr1, instr_sr2, instr_dr,
    output rdData1, rdData2,
    input  instr_ready, sr1, sr2, dr, wrData, write
  );

endinterface

// File: rtl/reg_alu_sequencer_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle. product_lo and
// done are combinational so the final step's sum is usable in the same cycle.
module seq_mul_shift_add #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product_lo,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic [DATA_W-1:0] step_sum;

  always_comb begin
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign product_lo = step_sum;
  assign done       = run_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/reg_alu_sequencer.sv
// Execute stage: accepts one reg-reg instruction, reads the bank, computes the
// ALU/MUL result and writes it back, with zero/carry flags.
module reg_alu_sequencer
  import reg_alu_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_alu_sequencer_if.slave  bus,
  output logic                done,
  output logic                zero_flag,
  output logic                carry_flag,
  output logic                busy
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [ADDR_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d, dr_q, dr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              write_q, write_d, done_q, done_d;
  logic              zero_q, zero_d, carry_q, carry_d;

  logic              mul_start, mul_done, exec_fin;
  logic [DATA_W-1:0] mul_prod, exec_res;
  logic [DATA_W:0]   alu_r;

  // Returns {carry, result}; MUL and NOP yield zero here.
  function automatic logic [DATA_W:0] alu(input op_e op, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb;
    logic [DATA_W:0]          r;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SLT:  r = {{DATA_W{1'b0}}, (sa < sb)};
      default: r = '0;
    endcase
    return r;
  endfunction

  seq_mul_shift_add #(.DATA_W(DATA_W)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .a          (bus.rdData1),
    .b          (bus.rdData2),
    .product_lo (mul_prod),
    .done       (mul_done)
  );

  assign alu_r    = alu(op_q, opa_q, opb_q);
  assign exec_res = (op_q == OP_MUL) ? mul_prod : alu_r[DATA_W-1:0];
  assign exec_fin = (op_q != OP_MUL) || mul_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr1_q    <= '0;
      sr2_q    <= '0;
      dr_q     <= '0;
      wrdata_q <= '0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      dr_q     <= dr_d;
      wrdata_q <= wrdata_d;
      write_q  <= write_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.instr_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    if (exec_fin) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // write/done/result registers load on the EXEC->WB edge so they are live in WB.
  always_comb begin
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    dr_d      = dr_q;
    wrdata_d  = wrdata_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    write_d   = 1'b0;
    done_d    = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          op_d  = op_e'(bus.instr_op);
          dr_d  = bus.instr_dr;
          sr1_d = bus.instr_sr1;
          sr2_d = bus.instr_sr2;
        end
      end
      READ: begin
        opa_d     = bus.rdData1;
        opb_d     = bus.rdData2;
        mul_start = (op_q == OP_MUL);
      end
      EXEC: begin
        if (exec_fin) begin
          done_d   = 1'b1;
          write_d  = (op_q != OP_NOP);
          wrdata_d = exec_res;
          if (op_q != OP_NOP) begin
            zero_d  = (exec_res == '0);
            carry_d = alu_r[DATA_W];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.instr_ready = rst_n && (state_q == IDLE);
  assign bus.sr1         = sr1_q;
  assign bus.sr2         = sr2_q;
  assign bus.dr          = dr_q;
  assign bus.wrData      = wrdata_q;
  assign bus.write       = write_q;
  assign done            = done_q;
  assign zero_flag       = zero_q;
  assign carry_flag      = carry_q;
  assign busy            = (state_q != IDLE);

endmodule
